// File: rtl/pll_reset_sequencer.sv
// rPLL power-up/relock sequencer with lock debounce and staggered domain reset release.
// Optional lock timeout with retry counting is enabled by defining PLL_SEQ_TIMEOUT_EN.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int NUM_DOMAINS         = 3,
  parameter int STAGE_GAP           = 8
) (
  input  logic                   clkin,
  input  logic                   rst_n,
  input  logic                   pll_lock,
  input  logic                   relock_req,
  output logic                   pll_reset,
  output logic [NUM_DOMAINS-1:0] sys_rst_n,
  output logic                   ready,
  output logic [7:0]             lock_lost_cnt,
  output logic [7:0]             retry_cnt,
  output logic [2:0]             state
);

  localparam int REL_LAST = STAGE_GAP * (NUM_DOMAINS - 1);
  localparam int PW = $clog2(PLL_RST_CYCLES) + 1;
  localparam int SW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int RW = $clog2(REL_LAST + 1) + 1;

  localparam logic [PW-1:0] PRST_LAST = PW'(PLL_RST_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] REL_END   = RW'(REL_LAST);

  typedef enum logic [2:0] {
    ST_PRST = 3'd0,
    ST_WAIT = 3'd1,
    ST_STAB = 3'd2,
    ST_REL  = 3'd3,
    ST_RUN  = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  logic                   sync1_r;
  logic                   lock_s_r;
  state_t                 state_r;
  state_t                 state_s;
  logic [PW-1:0]          prst_cnt_r;
  logic [PW-1:0]          prst_cnt_s;
  logic [SW-1:0]          stab_cnt_r;
  logic [SW-1:0]          stab_cnt_s;
  logic [RW-1:0]          rel_cnt_r;
  logic [RW-1:0]          rel_cnt_s;
  logic                   tmo_hit_s;
  logic                   lost_inc_s;
  logic                   pll_reset_r;
  logic                   pll_reset_s;
  logic [NUM_DOMAINS-1:0] sys_rst_n_r;
  logic [NUM_DOMAINS-1:0] sys_rst_n_s;
  logic                   ready_r;
  logic                   ready_s;
  logic [7:0]             lost_cnt_r;

`ifdef PLL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_r;
  logic [TW-1:0] tmo_cnt_s;
  logic          retry_inc_s;
  logic [7:0]    retry_cnt_r;

  assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

  // Timeout counter: counts lock-less WAIT cycles, survives STAB flaps, clears in PRST.
  always_comb begin
    tmo_cnt_s   = tmo_cnt_r;
    retry_inc_s = 1'b0;
    if (state_s == ST_PRST) begin
      tmo_cnt_s = TW'(0);
    end else if ((state_r == ST_WAIT) && (state_s == ST_WAIT) && !lock_s_r) begin
      tmo_cnt_s = tmo_cnt_r + TW'(1);
    end else begin
      tmo_cnt_s = tmo_cnt_r;
    end
    if ((state_r == ST_WAIT) && !lock_s_r && tmo_hit_s && !relock_req) begin
      retry_inc_s = 1'b1;
    end else begin
      retry_inc_s = 1'b0;
    end
  end

  // Timeout counter and saturating retry count registers.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r   <= TW'(0);
      retry_cnt_r <= 8'd0;
    end else begin
      tmo_cnt_r <= tmo_cnt_s;
      if (retry_inc_s) begin
        retry_cnt_r <= sat_inc(retry_cnt_r);
      end
    end
  end

  assign retry_cnt = retry_cnt_r;
`else
  assign tmo_hit_s = 1'b0;
  assign retry_cnt = 8'd0;
`endif

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= 1'b0;
      lock_s_r <= 1'b0;
    end else begin
      sync1_r  <= pll_lock;
      lock_s_r <= sync1_r;
    end
  end

  // Next-state and per-state counter logic.
  always_comb begin
    state_s    = state_r;
    prst_cnt_s = prst_cnt_r;
    stab_cnt_s = stab_cnt_r;
    rel_cnt_s  = rel_cnt_r;
    lost_inc_s = 1'b0;
    case (state_r)
      ST_PRST: begin
        if (relock_req) begin
          prst_cnt_s = PW'(0);
        end else if (prst_cnt_r == PRST_LAST) begin
          state_s = ST_WAIT;
        end else begin
          prst_cnt_s = prst_cnt_r + PW'(1);
        end
      end
      ST_WAIT: begin
        if (lock_s_r) begin
          state_s = ST_STAB;
        end else if (tmo_hit_s) begin
          state_s = ST_PRST;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_STAB: begin
        if (!lock_s_r) begin
          state_s = ST_WAIT;
        end else if (stab_cnt_r == STAB_LAST) begin
          state_s = ST_REL;
        end else begin
          stab_cnt_s = stab_cnt_r + SW'(1);
        end
      end
      ST_REL: begin
        if (!lock_s_r) begin
          state_s = ST_PRST;
        end else if (rel_cnt_r == REL_END) begin
          state_s = ST_RUN;
        end else begin
          rel_cnt_s = rel_cnt_r + RW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s_r) begin
          state_s    = ST_PRST;
          lost_inc_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_PRST;
      end
    endcase

    if (relock_req && (state_r != ST_PRST)) begin
      state_s = ST_PRST;
    end else begin
      state_s = state_s;
    end

    // Every counter starts from zero in a freshly entered state.
    if (state_s != state_r) begin
      prst_cnt_s = PW'(0);
      stab_cnt_s = SW'(0);
      rel_cnt_s  = RW'(0);
    end else begin
      prst_cnt_s = prst_cnt_s;
    end
  end

  // Output values for the upcoming state, so the outputs stay aligned with state.
  always_comb begin
    sys_rst_n_s = {NUM_DOMAINS{1'b0}};
    pll_reset_s = (state_s == ST_PRST);
    ready_s     = (state_s == ST_RUN);
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      sys_rst_n_s[i] = (state_s == ST_RUN) ||
                       ((state_s == ST_REL) && (rel_cnt_s >= RW'(STAGE_GAP * i)));
    end
  end

  // FSM state and sequencing counters.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_PRST;
      prst_cnt_r <= PW'(0);
      stab_cnt_r <= SW'(0);
      rel_cnt_r  <= RW'(0);
    end else begin
      state_r    <= state_s;
      prst_cnt_r <= prst_cnt_s;
      stab_cnt_r <= stab_cnt_s;
      rel_cnt_r  <= rel_cnt_s;
    end
  end

  // Registered outputs and the saturating lock-loss count.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      pll_reset_r <= 1'b1;
      sys_rst_n_r <= {NUM_DOMAINS{1'b0}};
      ready_r     <= 1'b0;
      lost_cnt_r  <= 8'd0;
    end else begin
      pll_reset_r <= pll_reset_s;
      sys_rst_n_r <= sys_rst_n_s;
      ready_r     <= ready_s;
      if (lost_inc_s) begin
        lost_cnt_r <= sat_inc(lost_cnt_r);
      end
    end
  end

  assign pll_reset     = pll_reset_r;
  assign sys_rst_n     = sys_rst_n_r;
  assign ready         = ready_r;
  assign lock_lost_cnt = lost_cnt_r;
  assign state         = state_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a timestamp-based reference model predicts
// every cycle's outputs; a separate monitor pops and compares. Honours PLL_SEQ_TIMEOUT_EN.
module tb_pll_reset_sequencer;

  localparam int P    = 4;
  localparam int N    = 8;
  localparam int D    = 3;
  localparam int GAP  = 2;
  localparam int T    = 32;
  localparam int LAST = GAP * (D - 1);

  logic         clkin = 1'b0;
  logic         rst_n = 1'b0;
  logic         pll_lock = 1'b0;
  logic         relock_req = 1'b0;
  logic         pll_reset;
  logic [D-1:0] sys_rst_n;
  logic         ready;
  logic [7:0]   lock_lost_cnt;
  logic [7:0]   retry_cnt;
  logic [2:0]   state;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(P), .LOCK_STABLE_CYCLES(N), .LOCK_TIMEOUT_CYCLES(T),
    .NUM_DOMAINS(D), .STAGE_GAP(GAP)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .relock_req(relock_req),
    .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .ready(ready),
    .lock_lost_cnt(lock_lost_cnt), .retry_cnt(retry_cnt), .state(state)
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic         pr;
    logic [D-1:0] sys;
    logic         rdy;
    logic [7:0]   lost;
    logic [7:0]   retry;
    logic [2:0]   st;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tmo_events = 0;
  int   tmo_seen = 0;

  // Reference model: the sequence is described by when PRST started (t0), when release
  // started (rel_t), the current run of synced-lock cycles and the lock-less WAIT count.
  int k, t0, rel_t, run_len, miss, m_lost, m_retry;
  bit rel, m_s1, m_ls;

  task automatic model_reset();
    k = 0; t0 = 0; rel_t = 0; run_len = 0; miss = 0;
    m_lost = 0; m_retry = 0; rel = 1'b0; m_s1 = 1'b0; m_ls = 1'b0;
  endtask

  task automatic restart(input int t);
    t0 = t; rel = 1'b0; run_len = 0; miss = 0;
  endtask

  task automatic model_step(input bit lk, input bit rq);
    bit in_prst, in_run;
    in_prst = !rel && ((k - t0) < P);
    in_run  = rel && ((k - rel_t) > LAST);
    if (rq) begin
      if (in_run && !m_ls && m_lost < 255) m_lost++;
      restart(k + 1);
    end else if (rel) begin
      if (!m_ls) begin
        if (in_run && m_lost < 255) m_lost++;
        restart(k + 1);
      end
    end else if (!in_prst) begin
      if (m_ls) begin
        run_len++;
        if (run_len == N + 1) begin
          rel = 1'b1;
          rel_t = k + 1;
        end
      end else begin
        if (run_len == 0) miss++;
        run_len = 0;
`ifdef PLL_SEQ_TIMEOUT_EN
        if (miss == T) begin
          if (m_retry < 255) m_retry++;
          restart(k + 1);
        end
`endif
      end
    end
    k++;
    m_ls = m_s1;
    m_s1 = lk;
  endtask

  function automatic obs_t predict();
    obs_t o;
    int e;
    o.pr = 1'b0; o.sys = '0; o.rdy = 1'b0;
    o.lost = 8'(m_lost); o.retry = 8'(m_retry);
    if (rel) begin
      e = k - rel_t;
      o.st  = (e > LAST) ? 3'd4 : 3'd3;
      o.rdy = (e > LAST);
      for (int i = 0; i < D; i++) o.sys[i] = (e >= GAP * i);
    end else if ((k - t0) < P) begin
      o.st = 3'd0;
      o.pr = 1'b1;
    end else begin
      o.st = (run_len > 0) ? 3'd2 : 3'd1;
    end
    return o;
  endfunction

  // Stimulus side of the scoreboard: predict each cycle's outputs as inputs are sampled.
  initial begin
    model_reset();
    forever begin
      @(posedge clkin);
      if (!rst_n) model_reset();
      else model_step(pll_lock, relock_req);
      exp_q.push_back(predict());
    end
  end

  // Monitor: compare the DUT against the oldest prediction, away from the clock edge.
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clkin);
      #1;
      if (tmo_events != tmo_seen) begin
        n_cmp += tmo_events - tmo_seen;
        n_bad += tmo_events - tmo_seen;
        tmo_seen = tmo_events;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pll_reset, sys_rst_n, ready, lock_lost_cnt, retry_cnt, state};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got pll_reset=%b sys_rst_n=%b ready=%b lost=%0d retry=%0d state=%0d, required pll_reset=%b sys_rst_n=%b ready=%b lost=%0d retry=%0d state=%0d",
                   $time, a.pr, a.sys, a.rdy, a.lost, a.retry, a.st,
                   e.pr, e.sys, e.rdy, e.lost, e.retry, e.st);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic wait_for(input logic [2:0] st, input int budget, input string what);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clkin);
      if (state == st) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tmo_events++;
      $display("FAIL wait_%s: state=%0d after %0d cycles, required %0d", what, state, budget, st);
    end
  endtask

  task automatic pulse_relock();
    relock_req = 1'b1;
    @(negedge clkin);
    relock_req = 1'b0;
  endtask

  initial begin
    int n;
    cyc(3);
    rst_n = 1'b1;
    cyc(80);
    pll_lock = 1'b1;
    wait_for(3'd4, 80, "first_run");
    cyc(5);

    // Lock glitch while stabilising, then a fresh full stable window.
    pulse_relock();
    wait_for(3'd2, 40, "stab");
    cyc(5);
    pll_lock = 1'b0;
    cyc(3);
    pll_lock = 1'b1;
    wait_for(3'd4, 80, "run_after_glitch");

    // Lock drop during staggered release.
    pulse_relock();
    wait_for(3'd3, 60, "rel");
    cyc(1);
    pll_lock = 1'b0;
    cyc(2);
    pll_lock = 1'b1;
    wait_for(3'd4, 80, "run_after_rel_drop");

    // Repeated lock loss in RUN drives the lost count into saturation.
    for (int r = 0; r < 300; r++) begin
      cyc($urandom_range(0, 4));
      pll_lock = 1'b0;
      cyc($urandom_range(1, 3));
      pll_lock = 1'b1;
      wait_for(3'd4, 80, "run_loop");
    end

    cyc(4);
    pulse_relock();
    wait_for(3'd4, 80, "run_after_relock");

    // Randomised lock flapping and relock pulses.
    for (int s = 0; s < 80; s++) begin
      pll_lock = ($urandom_range(0, 3) != 0);
      n = $urandom_range(1, 40);
      for (int c = 0; c < n; c++) begin
        relock_req = ($urandom_range(0, 59) == 0);
        @(negedge clkin);
      end
      relock_req = 1'b0;
    end

    // Asynchronous reset in mid-sequence clears everything, counts included.
    pll_lock = 1'b1;
    pulse_relock();
    cyc(10);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    wait_for(3'd4, 80, "run_after_reset");
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
